// File: rtl/pdl_puf_pkg.sv
// Shared definitions for the PDL arbiter-PUF evaluation controller.
//   state_e     : controller FSM encoding (3-bit)
//   EVAL_CNT_W  : width of the launch/eval counter
//   clog2_f     : ceil(log2(v)) helper usable in localparams
package pdl_puf_pkg;

   localparam int unsigned EVAL_CNT_W = 8;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSetup = 3'd1,
      StHigh  = 3'd2,
      StLow   = 3'd3,
      StDone  = 3'd4
   } state_e;

   // Returns at least 1 so a counter never collapses to zero width.
   function automatic int unsigned clog2_f(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/pdl_eval_ctrl_if.sv
// Signal bundle between the PUF evaluation controller and its neighbours.
//   start/challenge/resp_ready/arb_out : into the controller
//   select_tp/select_btm/launch        : to the pdl_switch chain
//   busy/resp/ones_cnt/resp_valid      : status and response
// modport slave is the controller side; master is the driver/consumer side.
interface pdl_eval_ctrl_if #(
   parameter int unsigned N_STAGES = 64
) ();

   logic                    start;
   logic [2*N_STAGES-1:0]   challenge;
   logic [N_STAGES-1:0]     select_tp;
   logic [N_STAGES-1:0]     select_btm;
   logic                    launch;
   logic                    arb_out;
   logic                    busy;
   logic                    resp;
   logic [7:0]              ones_cnt;
   logic                    resp_valid;
   logic                    resp_ready;

   modport master (
      output start, challenge, arb_out, resp_ready,
      input  select_tp, select_btm, launch, busy, resp, ones_cnt, resp_valid
   );

   modport slave (
      input  start, challenge, arb_out, resp_ready,
      output select_tp, select_btm, launch, busy, resp, ones_cnt, resp_valid
   );

endinterface

// File: rtl/arb_sync.sv
// Two-flop synchronizer for the asynchronous arbiter output.
//   clk, rst_n : clock, async active-low reset (both flops clear to 0)
//   d_i        : asynchronous input
//   q_o        : synchronized output
module arb_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/pdl_eval_ctrl.sv
// PDL arbiter-PUF evaluation controller: latches a challenge onto the switch-chain
// selects, fires N_EVAL launch pulses, samples the synchronized arbiter output at the
// end of each high phase and majority-votes the samples into one response bit.
//   clk, rst_n : clock, async active-low reset
//   bus        : pdl_eval_ctrl_if.slave (request, chain drive, arbiter input, response)
module pdl_eval_ctrl
   import pdl_puf_pkg::*;
#(
   parameter int unsigned N_STAGES   = 64,
   parameter int unsigned N_EVAL     = 15,
   parameter int unsigned SETUP_CYC  = 4,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   pdl_eval_ctrl_if.slave   bus
);

   if (SETTLE_CYC < 3) begin : g_bad_settle
      $error("pdl_eval_ctrl: SETTLE_CYC must be at least 3");
   end
   if (SETUP_CYC < 1) begin : g_bad_setup
      $error("pdl_eval_ctrl: SETUP_CYC must be at least 1");
   end
   if (N_EVAL < 1 || N_EVAL > 255) begin : g_bad_eval
      $error("pdl_eval_ctrl: N_EVAL must be in 1..255");
   end

   localparam int unsigned CNT_MAX = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
   localparam int unsigned CNT_W   = clog2_f(CNT_MAX + 1);

   // SETUP counts 0..SETUP_CYC: one cycle for the freshly latched selects to reach the
   // chain, then SETUP_CYC full hold cycles before the first launch edge.
   localparam logic [CNT_W-1:0]      SETUP_LAST  = CNT_W'(SETUP_CYC);
   localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [EVAL_CNT_W-1:0] EVAL_LAST   = EVAL_CNT_W'(N_EVAL - 1);
   localparam logic [7:0]            ONES_MAX    = 8'(N_EVAL);
   localparam logic [7:0]            ONES_HALF   = 8'(N_EVAL / 2);

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [EVAL_CNT_W-1:0]   eval_q;
   logic [N_STAGES-1:0]     sel_tp_q;
   logic [N_STAGES-1:0]     sel_btm_q;
   logic                    launch_q;
   logic                    resp_q;
   logic [7:0]              ones_q;
   logic                    valid_q;
   logic                    busy_q;
   logic                    arb_synced;

   (* keep_hierarchy = "yes" *)
   arb_sync u_arb_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.arb_out),
      .q_o   (arb_synced)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         eval_q    <= '0;
         sel_tp_q  <= '0;
         sel_btm_q <= '0;
         launch_q  <= 1'b0;
         resp_q    <= 1'b0;
         ones_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  sel_tp_q  <= bus.challenge[N_STAGES-1:0];
                  sel_btm_q <= bus.challenge[2*N_STAGES-1:N_STAGES];
                  ones_q    <= '0;
                  eval_q    <= '0;
                  cnt_q     <= '0;
                  resp_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_q    <= '0;
                  launch_q <= 1'b1;
                  state_q  <= StHigh;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StHigh: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q    <= '0;
                  launch_q <= 1'b0;
                  state_q  <= StLow;
                  if (arb_synced && (ones_q < ONES_MAX)) begin
                     ones_q <= ones_q + 8'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StLow: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q  <= '0;
                  eval_q <= eval_q + 1'b1;
                  if (eval_q == EVAL_LAST) begin
                     // ones_q is final here: the last sample landed on the HIGH exit.
                     resp_q  <= (ones_q > ONES_HALF);
                     valid_q <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     launch_q <= 1'b1;
                     state_q  <= StHigh;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (bus.resp_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.select_tp  = sel_tp_q;
   assign bus.select_btm = sel_btm_q;
   assign bus.launch     = launch_q;
   assign bus.busy       = busy_q;
   assign bus.resp       = resp_q;
   assign bus.ones_cnt   = ones_q;
   assign bus.resp_valid = valid_q;

   ones_cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
      ones_q <= ONES_MAX);

endmodule

// File: tb/tb_pdl_eval_ctrl.sv
// Self-checking bench for pdl_eval_ctrl (N_STAGES=4, N_EVAL=5, SETUP_CYC=2, SETTLE_CYC=4).
module tb_pdl_eval_ctrl;

   localparam int unsigned N_STAGES   = 4;
   localparam int unsigned N_EVAL     = 5;
   localparam int unsigned SETUP_CYC  = 2;
   localparam int unsigned SETTLE_CYC = 4;
   // First launch edge lands SETUP_CYC+1 edges after the start edge.
   localparam int FIRST = SETUP_CYC + 1;
   localparam int LAT   = FIRST + 2 * N_EVAL * SETTLE_CYC;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   pdl_eval_ctrl_if #(.N_STAGES(N_STAGES)) bus_if ();

   pdl_eval_ctrl #(
      .N_STAGES   (N_STAGES),
      .N_EVAL     (N_EVAL),
      .SETUP_CYC  (SETUP_CYC),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Launch is high for SETTLE_CYC cycles out of every 2*SETTLE_CYC during the run.
   function automatic bit exp_launch(input int d);
      if (d < FIRST || d >= LAT) return 1'b0;
      return ((d - FIRST) % (2 * SETTLE_CYC)) < SETTLE_CYC;
   endfunction

   // Caller is positioned just after a negedge with the DUT idle.
   task automatic run_eval(input logic [7:0] ch, input logic [4:0] pat, input int rd,
                           input bit start_at_hs, input bit start_in_high);
      int unsigned exp_ones;
      bit          exp_resp;
      exp_ones = $countones(pat);
      exp_resp = (exp_ones > N_EVAL / 2);
      bus_if.start     = 1'b1;
      bus_if.challenge = ch;
      bus_if.arb_out   = 1'b0;
      @(posedge clk);
      #1;
      bus_if.start     = 1'b0;
      bus_if.challenge = 8'($urandom);
      for (int d = 0; d <= LAT + rd; d++) begin
         @(negedge clk);
         check_eq("launch", 32'(bus_if.launch), 32'(exp_launch(d)));
         check_eq("busy", 32'(bus_if.busy), 32'd1);
         check_eq("resp_valid", 32'(bus_if.resp_valid), 32'(d >= LAT));
         if (d == 0 || d == LAT) begin
            check_eq("select_tp", 32'(bus_if.select_tp), 32'(ch[3:0]));
            check_eq("select_btm", 32'(bus_if.select_btm), 32'(ch[7:4]));
         end
         if (d >= LAT) begin
            check_eq("ones_cnt", 32'(bus_if.ones_cnt), exp_ones);
            check_eq("resp", 32'(bus_if.resp), 32'(exp_resp));
         end
         // Present each window's arbiter value as its launch edge rises.
         if (d >= FIRST && d < LAT && ((d - FIRST) % (2 * SETTLE_CYC)) == 0) begin
            bus_if.arb_out = pat[(d - FIRST) / (2 * SETTLE_CYC)];
         end
         if (start_in_high && d == FIRST + 1) begin
            bus_if.start     = 1'b1;
            bus_if.challenge = 8'hFF;
         end else if (start_in_high && d == FIRST + 2) begin
            bus_if.start = 1'b0;
         end
         if (d == LAT + rd) begin
            bus_if.resp_ready = 1'b1;
            if (start_at_hs) bus_if.start = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      bus_if.resp_ready = 1'b0;
      bus_if.start      = 1'b0;
      @(negedge clk);
      check_eq("hs_valid_drop", 32'(bus_if.resp_valid), 32'd0);
      check_eq("hs_busy_drop", 32'(bus_if.busy), 32'd0);
      check_eq("hs_launch", 32'(bus_if.launch), 32'd0);
      check_eq("hold_ones", 32'(bus_if.ones_cnt), exp_ones);
   endtask

   task automatic run_reset_mid();
      bus_if.start     = 1'b1;
      bus_if.challenge = 8'h3C;
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      // Third high window begins at FIRST + 4*SETTLE_CYC.
      for (int d = 0; d <= FIRST + 4 * SETTLE_CYC + 1; d++) begin
         @(negedge clk);
         check_eq("mid_launch", 32'(bus_if.launch), 32'(exp_launch(d)));
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_launch", 32'(bus_if.launch), 32'd0);
      check_eq("rst_async_busy", 32'(bus_if.busy), 32'd0);
      check_eq("rst_async_valid", 32'(bus_if.resp_valid), 32'd0);
      check_eq("rst_async_sel", 32'(bus_if.select_tp), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("post_rst_busy", 32'(bus_if.busy), 32'd0);
         check_eq("post_rst_valid", 32'(bus_if.resp_valid), 32'd0);
         check_eq("post_rst_launch", 32'(bus_if.launch), 32'd0);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus_if.start      = 1'b0;
      bus_if.challenge  = '0;
      bus_if.arb_out    = 1'b0;
      bus_if.resp_ready = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_launch", 32'(bus_if.launch), 32'd0);
         check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
         check_eq("rst_valid", 32'(bus_if.resp_valid), 32'd0);
         check_eq("rst_resp", 32'(bus_if.resp), 32'd0);
         check_eq("rst_ones", 32'(bus_if.ones_cnt), 32'd0);
         check_eq("rst_sel", 32'({bus_if.select_btm, bus_if.select_tp}), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("idle_launch", 32'(bus_if.launch), 32'd0);
         check_eq("idle_busy", 32'(bus_if.busy), 32'd0);
      end

      run_eval(8'hA5, 5'b11111, 0, 1'b0, 1'b0);
      run_eval(8'($urandom), 5'b01101, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      run_eval(8'($urandom), 5'b00011, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      run_eval(8'($urandom), 5'($urandom), 10, 1'b1, 1'b0);
      run_eval(8'h12, 5'($urandom), 1, 1'b0, 1'b1);
      run_reset_mid();
      run_eval(8'($urandom), 5'($urandom), 0, 1'b0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         run_eval(8'($urandom), 5'($urandom), int'($urandom_range(0, 6)),
                  1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
